// File: rtl/fnd_pkg.sv
// Shared constants, segment decoder and conversion-FSM encoding for the FND scan path.
package fnd_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Active-low common-anode pattern, bit 7 = dp (off), bits 6..0 = g..a
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg_v;
        case (nib)
            4'h0:    seg_v = 8'hC0;
            4'h1:    seg_v = 8'hF9;
            4'h2:    seg_v = 8'hA4;
            4'h3:    seg_v = 8'hB0;
            4'h4:    seg_v = 8'h99;
            4'h5:    seg_v = 8'h92;
            4'h6:    seg_v = 8'h82;
            4'h7:    seg_v = 8'hF8;
            4'h8:    seg_v = 8'h80;
            4'h9:    seg_v = 8'h90;
            4'hA:    seg_v = 8'h88;
            4'hB:    seg_v = 8'h83;
            4'hC:    seg_v = 8'hC6;
            4'hD:    seg_v = 8'hA1;
            4'hE:    seg_v = 8'h86;
            4'hF:    seg_v = 8'h8E;
            default: seg_v = SEG_BLANK;
        endcase
        return seg_v;
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] acc_v;
        acc_v = 32'd1;
        for (int i = 0; i < n; i++) begin
            acc_v = acc_v * 32'd10;
        end
        return acc_v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, DATA_W steps,
// then a single COMMIT cycle that flags done.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    conv_state_e        state_r;
    conv_state_e        state_s;
    logic [DATA_W-1:0]  bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BCD_W-1:0]   bcd_adj_s;
    logic [BCD_W-1:0]   bcd_step_s;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE:   state_s = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT:  state_s = (cnt_r == CNT_W'(1)) ? ST_COMMIT : ST_SHIFT;
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_r != ST_IDLE);
        done = (state_r == ST_COMMIT);
    end

    // One double-dabble step: correct nibbles >= 5, then shift in the next MSB
    always_comb begin
        bcd_adj_s = bcd_r;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            bcd_adj_s[4*d +: 4] = (bcd_r[4*d +: 4] >= 4'd5) ? (bcd_r[4*d +: 4] + 4'd3)
                                                             : bcd_r[4*d +: 4];
        end
        bcd_step_s = {bcd_adj_s[BCD_W-2:0], bin_r[DATA_W-1]};
    end

    // Conversion datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_r <= {DATA_W{1'b0}};
            bcd_r <= {BCD_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bin_r <= value;
                        bcd_r <= {BCD_W{1'b0}};
                        cnt_r <= CNT_W'(DATA_W);
                    end
                end
                ST_SHIFT: begin
                    bin_r <= {bin_r[DATA_W-2:0], 1'b0};
                    bcd_r <= bcd_step_s;
                    cnt_r <= cnt_r - 1'b1;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: sequential BCD conversion, digit scan,
// blink phase and per-digit pattern selection into registered segment/common outputs.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 14,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     i_value,
    input  logic [NUM_DIGITS-1:0] i_dp,
    input  logic [NUM_DIGITS-1:0] i_blink,
    input  logic                  i_blank_lz,
    input  logic                  i_load,
    output logic                  o_busy,
    output logic [7:0]            fnd_data,
    output logic [NUM_DIGITS-1:0] fnd_com
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = $clog2(BLINK_TICKS + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam logic [31:0] VAL_MAX = pow10(NUM_DIGITS) - 32'd1;
    localparam logic [NUM_DIGITS-1:0] DIGIT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic                  busy_s;
    logic                  done_s;
    logic [BCD_W-1:0]      bcd_s;
    logic [NUM_DIGITS-1:0] pend_dp_r, pend_blink_r;
    logic                  pend_ovf_r;
    logic [BCD_W-1:0]      disp_bcd_r;
    logic [NUM_DIGITS-1:0] disp_dp_r, disp_blink_r;
    logic                  disp_ovf_r;
    logic [DIV_W-1:0]      div_cnt_r;
    logic                  tick_s;
    logic [IDX_W-1:0]      idx_r;
    logic [BLK_W-1:0]      blk_cnt_r;
    logic                  blink_phase_r;
    logic [3:0]            nib_s;
    logic                  dp_s, blink_s, lz_s, zero_run_s;
    logic [7:0]            seg_s;
    logic [NUM_DIGITS-1:0] com_s;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (i_load),
        .value (i_value),
        .busy  (busy_s),
        .done  (done_s),
        .bcd   (bcd_s)
    );

    assign o_busy = busy_s;
    assign tick_s = (div_cnt_r == DIV_W'(DIV - 1));

    // Attributes are held aside during conversion so the display switches atomically at commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_dp_r    <= {NUM_DIGITS{1'b0}};
            pend_blink_r <= {NUM_DIGITS{1'b0}};
            pend_ovf_r   <= 1'b0;
            disp_bcd_r   <= {BCD_W{1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            disp_blink_r <= {NUM_DIGITS{1'b0}};
            disp_ovf_r   <= 1'b0;
        end else begin
            if (i_load && !busy_s) begin
                pend_dp_r    <= i_dp;
                pend_blink_r <= i_blink;
                pend_ovf_r   <= ({{(32-DATA_W){1'b0}}, i_value} > VAL_MAX);
            end
            if (done_s) begin
                disp_bcd_r   <= bcd_s;
                disp_dp_r    <= pend_dp_r;
                disp_blink_r <= pend_blink_r;
                disp_ovf_r   <= pend_ovf_r;
            end
        end
    end

    // Scan prescaler, digit index and blink phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r     <= {DIV_W{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            blk_cnt_r     <= {BLK_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else begin
            div_cnt_r <= tick_s ? {DIV_W{1'b0}} : (div_cnt_r + 1'b1);
            if (tick_s) begin
                idx_r <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? {IDX_W{1'b0}} : (idx_r + 1'b1);
                if (blk_cnt_r == BLK_W'(BLINK_TICKS - 1)) begin
                    blk_cnt_r     <= {BLK_W{1'b0}};
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    blk_cnt_r <= blk_cnt_r + 1'b1;
                end
            end
        end
    end

    // Select the current digit; zero_run tracks "this and all higher digits are zero"
    always_comb begin
        nib_s      = 4'h0;
        dp_s       = 1'b0;
        blink_s    = 1'b0;
        lz_s       = 1'b0;
        zero_run_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s = zero_run_s & (disp_bcd_r[4*k +: 4] == 4'h0);
            nib_s      = (idx_r == IDX_W'(k)) ? disp_bcd_r[4*k +: 4] : nib_s;
            dp_s       = (idx_r == IDX_W'(k)) ? disp_dp_r[k] : dp_s;
            blink_s    = (idx_r == IDX_W'(k)) ? disp_blink_r[k] : blink_s;
            lz_s       = (idx_r == IDX_W'(k)) ? (zero_run_s & (k != 32'sd0)) : lz_s;
        end
        if (disp_ovf_r) begin
            seg_s = SEG_DASH;
        end else if (blink_phase_r && blink_s) begin
            seg_s = SEG_BLANK;
        end else if (i_blank_lz && lz_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(nib_s) & {~dp_s, 7'h7F};
        end
        com_s = ~(DIGIT0 << idx_r);
    end

    // Registered display outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fnd_data <= 8'hC0;
            fnd_com  <= ~DIGIT0;
        end else begin
            fnd_data <= seg_s;
            fnd_com  <= com_s;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with an arithmetic reference model checked every cycle
// plus literal spot checks of individual digits.
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] i_value = 14'd0;
    logic [3:0]  i_dp = 4'd0;
    logic [3:0]  i_blink = 4'd0;
    logic        i_blank_lz = 1'b0;
    logic        i_load = 1'b0;
    logic        o_busy;
    logic [7:0]  fnd_data;
    logic [3:0]  fnd_com;

    int total = 0;
    int bad = 0;
    int nprint = 0;
    bit chk_en = 1'b0;

    fnd_scan_ctrl #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .NUM_DIGITS  (4),
        .DATA_W      (14),
        .BLINK_TICKS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_value    (i_value),
        .i_dp       (i_dp),
        .i_blink    (i_blink),
        .i_blank_lz (i_blank_lz),
        .i_load     (i_load),
        .o_busy     (o_busy),
        .fnd_data   (fnd_data),
        .fnd_com    (fnd_com)
    );

    always #5 clk = ~clk;

    logic [7:0] dec_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference: what digit k of decimal value v must look like
    function automatic logic [7:0] expect_seg(input int k, input int v, input logic [3:0] dp,
                                              input logic [3:0] bl, input int ph, input logic blz);
        int p;
        logic [7:0] s;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v > 9999) return 8'hBF;
        if (ph != 0 && bl[k]) return 8'hFF;
        if (blz && k > 0 && v < p) return 8'hFF;
        s = dec_tab[(v / p) % 10];
        if (dp[k]) s[7] = 1'b0;
        return s;
    endfunction

    // Model state: edges since reset, conversion countdown, shown and pending values
    int         m_cyc = 0;
    int         m_rem = 0;
    int         m_val = 0, p_val = 0;
    logic [3:0] m_dp = 4'd0, m_bl = 4'd0, p_dp = 4'd0, p_bl = 4'd0;
    logic [7:0] exp_data = 8'hC0;
    logic [3:0] exp_com = 4'b1110;
    logic       exp_busy = 1'b0;

    // Ticks = edges/10, index = ticks mod 4, blink phase = (ticks/2) mod 2
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc    <= 0;
            m_rem    <= 0;
            m_val    <= 0;
            m_dp     <= 4'd0;
            m_bl     <= 4'd0;
            exp_data <= 8'hC0;
            exp_com  <= 4'b1110;
            exp_busy <= 1'b0;
        end else begin
            exp_com  <= ~(4'b0001 << ((m_cyc / 10) % 4));
            exp_data <= expect_seg((m_cyc / 10) % 4, m_val, m_dp, m_bl,
                                   ((m_cyc / 10) / 2) % 2, i_blank_lz);
            m_cyc    <= m_cyc + 1;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_val <= p_val;
                    m_dp  <= p_dp;
                    m_bl  <= p_bl;
                end
            end else if (i_load) begin
                m_rem <= 15;
                p_val <= int'(i_value);
                p_dp  <= i_dp;
                p_bl  <= i_blink;
            end
            exp_busy <= (m_rem > 1) || (m_rem == 0 && i_load);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                total++;
                if ({fnd_data, fnd_com, o_busy} !== {exp_data, exp_com, exp_busy}) begin
                    bad++;
                    if (nprint < 40) begin
                        nprint++;
                        $display("FAIL model t=%0t: data=%h com=%b busy=%b expected data=%h com=%b busy=%b",
                                 $time, fnd_data, fnd_com, o_busy, exp_data, exp_com, exp_busy);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input int v, input logic [3:0] dp, input logic [3:0] bl);
        i_value = 14'(v);
        i_dp    = dp;
        i_blink = bl;
        i_load  = 1'b1;
        @(posedge clk);
        #2;
        i_load  = 1'b0;
    endtask

    task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    task automatic see_digit(input int k, input logic [7:0] want, input string nm);
        logic [3:0] sel;
        bit found;
        sel = ~(4'b0001 << k);
        found = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (fnd_com == sel) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: digit %0d never selected (com=%b)", nm, k, fnd_com);
        end else begin
            check_val(nm, fnd_data, want);
        end
    endtask

    initial begin
        int nbusy;
        step(3);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset mid-scan
        step(25);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_com", {4'h0, fnd_com}, 8'h0E);
        check_val("rst_data", fnd_data, 8'hC0);
        check_val("rst_busy", {7'd0, o_busy}, 8'h00);
        step(1);
        reset = 1'b0;

        // 1234 with dp on digit 2, busy width
        step(1);
        pulse(1234, 4'b0100, 4'b0000);
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_busy) nbusy++;
        end
        check_val("busy_len", 8'(nbusy), 8'd15);
        see_digit(3, 8'hF9, "d3_1234");
        see_digit(2, 8'h24, "d2_1234");
        see_digit(1, 8'hB0, "d1_1234");
        see_digit(0, 8'h99, "d0_1234");

        // Leading-zero blanking, sampled live
        step(1);
        i_blank_lz = 1'b1;
        pulse(7, 4'b0000, 4'b0000);
        step(20);
        see_digit(3, 8'hFF, "d3_lz");
        see_digit(1, 8'hFF, "d1_lz");
        see_digit(0, 8'hF8, "d0_lz");
        step(1);
        i_blank_lz = 1'b0;
        see_digit(1, 8'hC0, "d1_nolz");

        // Overflow dash, then the largest in-range value
        step(1);
        pulse(10000, 4'hF, 4'b0000);
        step(20);
        see_digit(0, 8'hBF, "d0_ovf");
        see_digit(3, 8'hBF, "d3_ovf");
        step(1);
        pulse(9999, 4'h0, 4'b0000);
        step(20);
        see_digit(2, 8'h90, "d2_9999");

        // Blink: index and phase stay locked, so digit 2 always lands in the blank phase
        step(1);
        pulse(42, 4'h0, 4'b0101);
        step(20);
        see_digit(0, 8'hA4, "d0_blink");
        see_digit(1, 8'h99, "d1_blink");
        see_digit(2, 8'hFF, "d2_blink");

        // Load while busy is dropped
        step(1);
        pulse(5, 4'h0, 4'h0);
        step(2);
        pulse(8, 4'h0, 4'h0);
        step(20);
        see_digit(0, 8'h92, "d0_drop");

        // Load during COMMIT ignored, next cycle accepted
        step(1);
        pulse(11, 4'h0, 4'h0);
        step(14);
        pulse(22, 4'h0, 4'h0);
        pulse(33, 4'h0, 4'h0);
        step(20);
        see_digit(1, 8'hB0, "d1_commit");
        see_digit(0, 8'hB0, "d0_commit");

        // Reset mid-conversion aborts and clears the display
        step(1);
        pulse(1234, 4'h0, 4'h0);
        step(5);
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_busy", {7'd0, o_busy}, 8'h00);
        step(1);
        reset = 1'b0;
        see_digit(0, 8'hC0, "d0_abort");
        see_digit(1, 8'hC0, "d1_abort");
        check_val("abort_busy2", {7'd0, o_busy}, 8'h00);

        step(30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
